// File: rtl/mm8_pkg.sv
// Shared types for the 8x8 matrix-multiply job controller: dimensions,
// element/row/matrix containers and the controller state encoding.
package mm8_pkg;

  localparam int unsigned N         = 8;
  localparam int unsigned DEF_WIDTH = 16;

  // Default-width containers; modules with a different WIDTH redeclare locally.
  typedef logic [2*DEF_WIDTH-1:0] elem_t;
  typedef elem_t [N-1:0]          row_t;
  typedef row_t  [N-1:0]          mat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_mul8_sched.sv
// Job controller for matrix_multi8: loads A/B as a 16-row stream, holds them
// on the datapath operands, waits MUL_LAT cycles, then streams C out by row.
module matrix_mul8_sched
  import mm8_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [4:0]                          cfg_m_bit1,
  input  logic [4:0]                          cfg_m_bit2,
  input  logic                                cfg_flag,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N*2*WIDTH-1:0]                in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N*2*WIDTH-1:0]                out_data,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done,
  output logic [N-1:0][N-1:0][2*WIDTH-1:0]    mm_A,
  output logic [N-1:0][N-1:0][2*WIDTH-1:0]    mm_B,
  output logic [4:0]                          mm_m_bit1,
  output logic [4:0]                          mm_m_bit2,
  output logic                                mm_flag,
  input  logic [N-1:0][N-1:0][2*WIDTH-1:0]    mm_C
);

  localparam int unsigned EW    = 2*WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(2*N - 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(N - 1);

  typedef logic [EW-1:0]   elem_w_t;
  typedef elem_w_t [N-1:0] row_w_t;
  typedef row_w_t  [N-1:0] mat_w_t;

  state_t           state;
  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] lat_cnt;
  mat_w_t           a_buf;
  mat_w_t           b_buf;
  mat_w_t           c_buf;
  row_w_t           in_row;
  row_w_t           out_row;

  // Row unpack/pack between the flat stream buses and element arrays.
  for (genvar j = 0; j < N; j++) begin : g_row
    assign in_row[j]              = in_data[j*EW +: EW];
    assign out_data[j*EW +: EW]   = out_row[j];
  end

  assign out_row   = c_buf[row_cnt[2:0]];
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (row_cnt == C_LAST);
  assign busy      = (state != IDLE);
  assign mm_A      = a_buf;
  assign mm_B      = b_buf;

  // Controller FSM, counters and operand/result buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      lat_cnt   <= '0;
      a_buf     <= '0;
      b_buf     <= '0;
      c_buf     <= '0;
      mm_m_bit1 <= '0;
      mm_m_bit2 <= '0;
      mm_flag   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Abort wins over any same-cycle beat; buffers are left untouched.
        state   <= IDLE;
        row_cnt <= '0;
        lat_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mm_m_bit1 <= cfg_m_bit1;
              mm_m_bit2 <= cfg_m_bit2;
              mm_flag   <= cfg_flag;
              row_cnt   <= '0;
              state     <= LOAD;
            end
          end
          LOAD: begin
            if (in_valid) begin
              if (!row_cnt[3]) a_buf[row_cnt[2:0]] <= in_row;
              else             b_buf[row_cnt[2:0]] <= in_row;
              row_cnt <= row_cnt + CNT_W'(1);
              if (row_cnt == ROW_LAST) begin
                lat_cnt <= '0;
                state   <= WAIT;
              end
            end
          end
          WAIT: begin
            if (lat_cnt == LAT_LAST) begin
              c_buf   <= mm_C;
              row_cnt <= '0;
              state   <= DRAIN;
            end else begin
              lat_cnt <= lat_cnt + CNT_W'(1);
            end
          end
          DRAIN: begin
            if (out_ready) begin
              row_cnt <= row_cnt + CNT_W'(1);
              if (row_cnt == C_LAST) begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_mul8_sched.sv
// Scoreboard bench for matrix_mul8_sched with a pipelined stub multiplier
// and a plain-arithmetic matrix product as the reference.
module tb_matrix_mul8_sched;
  import mm8_pkg::*;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned EW         = 2*WIDTH;
  localparam int unsigned RW         = N*EW;
  localparam int unsigned MUL_LAT    = 4;
  localparam int unsigned STUB_DEPTH = MUL_LAT - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [4:0] cfg_m_bit1 = '0;
  logic [4:0] cfg_m_bit2 = '0;
  logic cfg_flag = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [RW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic out_last, busy, done;
  logic [N-1:0][N-1:0][EW-1:0] mm_A, mm_B, mm_C, prod_c;
  logic [4:0] mm_m_bit1, mm_m_bit2;
  logic mm_flag;
  logic [N-1:0][N-1:0][EW-1:0] pipe [STUB_DEPTH];

  matrix_mul8_sched #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_m_bit1(cfg_m_bit1), .cfg_m_bit2(cfg_m_bit2), .cfg_flag(cfg_flag),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done),
    .mm_A(mm_A), .mm_B(mm_B), .mm_m_bit1(mm_m_bit1), .mm_m_bit2(mm_m_bit2),
    .mm_flag(mm_flag), .mm_C(mm_C)
  );

  always #5 clk = ~clk;

  // Stub datapath: product of the held operands through a short register pipe.
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          prod_c[i][j] = prod_c[i][j] + mm_A[i][k] * mm_B[k][j];
  end

  always @(posedge clk) begin
    pipe[0] <= prod_c;
    for (int s = 1; s < STUB_DEPTH; s++) pipe[s] <= pipe[s-1];
  end
  assign mm_C = pipe[STUB_DEPTH-1];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;
  int drain_idx = 0;
  int bp_cnt   = 0;
  bit bp_mode  = 1'b0;
  bit hold_pending = 1'b0;
  logic [RW:0] held;
  logic [RW:0] exp_q[$];
  int unsigned cur_a [N][N];
  int unsigned cur_b [N][N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [RW:0] act, input logic [RW:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endfunction

  function automatic void chk_int(input string name, input int act, input int want);
    check(name, (RW+1)'(act), (RW+1)'(want));
  endfunction

  function automatic logic [RW-1:0] row_of(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      if (r < N) v[j*EW +: EW] = EW'(cur_a[r][j]);
      else       v[j*EW +: EW] = EW'(cur_b[r-N][j]);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cur_a[i][j] = $urandom;
        cur_b[i][j] = $urandom;
      end
  endtask

  // Reference: C = A x B with 32-bit wraparound, queued as rows with last flag.
  task automatic push_expected();
    for (int i = 0; i < N; i++) begin
      logic [RW-1:0] row;
      int unsigned acc;
      row = '0;
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += cur_a[i][k] * cur_b[k][j];
        row[j*EW +: EW] = EW'(acc);
      end
      exp_q.push_back({(i == N-1), row});
    end
  endtask

  task automatic start_job(input logic [4:0] m1, input logic [4:0] m2, input logic f);
    cfg_m_bit1 = m1; cfg_m_bit2 = m2; cfg_flag = f;
    drain_idx = 0; bp_cnt = 0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    chk_int("in_ready_after_start", int'(in_ready), 1);
  endtask

  task automatic load_rows(input bit gappy, input int abort_at, output bit aborted);
    aborted = 1'b0;
    for (int b = 0; b < 2*N; b++) begin
      if (gappy && b > 0) begin
        in_valid = 1'b0; in_data = '1;
        tick();
      end
      in_valid = 1'b1; in_data = row_of(b);
      abort = (b == abort_at);
      tick();
      if (abort) begin
        abort = 1'b0; aborted = 1'b1;
        break;
      end
    end
    in_valid = 1'b0; in_data = '0;
    if (!aborted) push_expected();
  endtask

  task automatic wait_done(output int lat, output int first_ov, output int last_at);
    lat = -1; first_ov = -1; last_at = -1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (out_valid && first_ov < 0) first_ov = cyc - t0;
      if (out_last && last_at < 0) last_at = cyc - t0;
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    chk_int("done_seen", int'(lat >= 0), 1);
  endtask

  // Output backpressure: row 3 is stalled for three cycles in bp_mode.
  always @(posedge clk) begin
    #1;
    if (bp_mode && out_valid && drain_idx == 3 && bp_cnt < 3) begin
      out_ready = 1'b0;
      bp_cnt++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: compare each accepted row against the scoreboard; check hold.
  always @(negedge clk) begin
    if (rst || !out_valid) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("hold_row", {out_last, out_data}, held);
      if (out_ready) begin
        chk_int("row_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("out_row", {out_last, out_data}, exp_q.pop_front());
        drain_idx++;
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held = {out_last, out_data};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, fov, lat_last, dcnt;
    bit ab;
    logic [RW-1:0] saved_b1;

    tick(); tick();
    rst = 1'b0;
    chk_int("rst_in_ready", int'(in_ready), 0);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_out_last", int'(out_last), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    chk_int("rst_m1", int'(mm_m_bit1), 0);
    chk_int("rst_m2", int'(mm_m_bit2), 0);
    chk_int("rst_flag", int'(mm_flag), 0);
    check("rst_out_data", {1'b0, out_data}, '0);
    for (int r = 0; r < N; r++) begin
      check("rst_mm_A", {1'b0, mm_A[r]}, '0);
      check("rst_mm_B", {1'b0, mm_B[r]}, '0);
    end

    // Basic job: identity x pattern.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cur_a[i][j] = (i == j) ? 1 : 0;
        cur_b[i][j] = i*8 + j;
      end
    start_job(5'd3, 5'd4, 1'b0);
    load_rows(1'b0, -1, ab);
    wait_done(lat, fov, lat_last);
    chk_int("basic_done_cycle", lat, 25 + MUL_LAT);
    chk_int("basic_first_valid", fov, 17 + MUL_LAT);
    chk_int("basic_last_cycle", lat_last, 24 + MUL_LAT);
    chk_int("basic_busy_at_done", int'(busy), 0);
    chk_int("basic_m1", int'(mm_m_bit1), 3);
    tick();
    chk_int("basic_done_pulse", int'(done), 0);

    // Config latch with input gaps and output stall.
    gen_random();
    bp_mode = 1'b1;
    start_job(5'd10, 5'd7, 1'b1);
    cfg_m_bit1 = '0; cfg_m_bit2 = '0; cfg_flag = 1'b0;
    load_rows(1'b1, -1, ab);
    chk_int("cfg_m1_wait", int'(mm_m_bit1), 10);
    chk_int("cfg_m2_wait", int'(mm_m_bit2), 7);
    chk_int("cfg_flag_wait", int'(mm_flag), 1);
    wait_done(lat, fov, lat_last);
    chk_int("bp_done_cycle", lat, 43 + MUL_LAT);
    chk_int("bp_stall_cycles", bp_cnt, 3);
    chk_int("cfg_m1_done", int'(mm_m_bit1), 10);
    chk_int("cfg_flag_done", int'(mm_flag), 1);
    bp_mode = 1'b0;
    tick();

    // Abort on beat 9: beat dropped, no done.
    saved_b1 = row_of(N + 1);
    gen_random();
    start_job(5'd2, 5'd2, 1'b0);
    load_rows(1'b0, 9, ab);
    chk_int("abort_taken", int'(ab), 1);
    chk_int("abort_busy", int'(busy), 0);
    chk_int("abort_in_ready", int'(in_ready), 0);
    check("abort_b1_kept", {1'b0, mm_B[1]}, {1'b0, saved_b1});
    check("abort_b0_new", {1'b0, mm_B[0]}, {1'b0, row_of(N)});
    check("abort_a7_new", {1'b0, mm_A[7]}, {1'b0, row_of(7)});
    chk_int("abort_m1", int'(mm_m_bit1), 2);
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) dcnt++;
    end
    chk_int("abort_no_done", dcnt, 0);

    // Fresh job after abort.
    gen_random();
    start_job(5'd9, 5'd11, 1'b1);
    load_rows(1'b0, -1, ab);
    wait_done(lat, fov, lat_last);
    chk_int("post_abort_done_cycle", lat, 25 + MUL_LAT);
    tick();

    // Reset while row 5 is presented.
    gen_random();
    start_job(5'd5, 5'd6, 1'b1);
    load_rows(1'b0, -1, ab);
    dcnt = 0;
    while (!(out_valid && drain_idx == 5) && dcnt < 100) begin
      tick();
      dcnt++;
    end
    chk_int("reached_row5", int'(out_valid && drain_idx == 5), 1);
    rst = 1'b1;
    tick();
    chk_int("mid_rst_busy", int'(busy), 0);
    chk_int("mid_rst_out_valid", int'(out_valid), 0);
    chk_int("mid_rst_m1", int'(mm_m_bit1), 0);
    chk_int("mid_rst_flag", int'(mm_flag), 0);
    check("mid_rst_out_data", {out_last, out_data}, '0);
    check("mid_rst_mm_A0", {1'b0, mm_A[0]}, '0);
    check("mid_rst_mm_B7", {1'b0, mm_B[7]}, '0);
    rst = 1'b0;
    exp_q.delete();
    tick();

    // Back-to-back with start held high.
    gen_random();
    cfg_m_bit1 = 5'd1; cfg_m_bit2 = 5'd2; cfg_flag = 1'b0;
    drain_idx = 0;
    start = 1'b1;
    t0 = cyc;
    tick();
    load_rows(1'b0, -1, ab);
    wait_done(lat, fov, lat_last);
    chk_int("b2b_first_done", lat, 25 + MUL_LAT);
    chk_int("b2b_idle_at_done", int'(in_ready), 0);
    gen_random();
    drain_idx = 0;
    t0 = cyc;
    tick();
    start = 1'b0;
    chk_int("b2b_load_next", int'(in_ready), 1);
    load_rows(1'b0, -1, ab);
    wait_done(lat, fov, lat_last);
    chk_int("b2b_second_done", lat, 25 + MUL_LAT);

    tick(); tick();
    chk_int("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
